// File: rtl/tx_serializer_10b_if.sv
// Symbol handshake into the 10b serializer plus its serial, disparity and status outputs.
// master = upstream encoder side, slave = serializer side.
interface tx_serializer_10b_if;
  logic [9:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       disp_out;
  logic       disp_err;
  logic       underrun;

  modport master (
    output sym_in, sym_valid,
    input  sym_ready, ser_out, ser_valid, disp_out, disp_err, underrun
  );

  modport slave (
    input  sym_in, sym_valid,
    output sym_ready, ser_out, ser_valid, disp_out, disp_err, underrun
  );
endinterface

// File: rtl/tx_serializer_10b.sv
// 10b symbol serializer with running-disparity tracking; first bit 1 clk after accept, ready only in IDLE or on bit 9.
// IDLE_FILL_EN: on underrun self-load K28.5 for the current RD instead of idling the line.
module tx_serializer_10b #(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit RD_INIT   = 1'b0
) (
  input logic           clk,
  input logic           rst,
  tx_serializer_10b_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [9:0] shreg, shreg_nxt;
  logic       ser_out_q, ser_out_nxt;
  logic       ser_valid_q, ser_valid_nxt;
  logic       rd_q, rd_nxt;
  logic       err_q, err_nxt;
  logic       urun_q, urun_nxt;

  logic       at_end;
  logic       sym_ready;
  logic       accept;
  logic       fill;
  logic       load;
  logic [9:0] fill_sym;
  logic [9:0] load_sym;
  logic [9:0] ord_sym;
  logic [3:0] ones;
  logic       rd_upd;
  logic       err_upd;

  assign at_end    = (state == IDLE) || (bit_cnt == 4'd9);
  assign sym_ready = !rst && at_end;
  assign accept    = bus.sym_valid && sym_ready;

`ifdef IDLE_FILL_EN
  assign fill     = at_end && !accept;
  assign fill_sym = rd_q ? 10'b1100000101 : 10'b0011111010;
`else
  assign fill     = 1'b0;
  assign fill_sym = 10'b0;
`endif

  assign load = accept || fill;

  // Symbol is normalised so the shifter always emits ord_sym[9] first.
  always_comb begin
    load_sym = accept ? bus.sym_in : fill_sym;
    ord_sym  = '0;
    ones     = '0;
    for (int i = 0; i < 10; i++) begin
      ord_sym[i] = MSB_FIRST ? load_sym[i] : load_sym[9-i];
      ones       = ones + {3'b000, load_sym[i]};
    end
  end

  always_comb begin
    rd_upd  = rd_q;
    err_upd = 1'b0;
    if (ones == 4'd5) begin
      rd_upd = rd_q;
    end else if (ones == 4'd6 && !rd_q) begin
      rd_upd = 1'b1;
    end else if (ones == 4'd4 && rd_q) begin
      rd_upd = 1'b0;
    end else begin
      err_upd = 1'b1;
      rd_upd  = (ones > 4'd5);
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    ser_out_nxt   = ser_out_q;
    ser_valid_nxt = ser_valid_q;
    rd_nxt        = rd_q;
    err_nxt       = 1'b0;
    urun_nxt      = (state == SHIFT) && (bit_cnt == 4'd9) && !accept;

    if (load) begin
      state_nxt     = SHIFT;
      bit_cnt_nxt   = 4'd0;
      ser_out_nxt   = ord_sym[9];
      shreg_nxt     = {ord_sym[8:0], 1'b0};
      ser_valid_nxt = 1'b1;
      rd_nxt        = rd_upd;
      err_nxt       = err_upd;
    end else if (state == SHIFT && bit_cnt != 4'd9) begin
      bit_cnt_nxt   = bit_cnt + 4'd1;
      ser_out_nxt   = shreg[9];
      shreg_nxt     = {shreg[8:0], 1'b0};
      ser_valid_nxt = 1'b1;
    end else begin
      state_nxt     = IDLE;
      bit_cnt_nxt   = 4'd0;
      ser_out_nxt   = 1'b0;
      shreg_nxt     = '0;
      ser_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      rd_q        <= RD_INIT;
      err_q       <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      ser_out_q   <= ser_out_nxt;
      ser_valid_q <= ser_valid_nxt;
      rd_q        <= rd_nxt;
      err_q       <= err_nxt;
      urun_q      <= urun_nxt;
    end
  end

  assign bus.sym_ready = sym_ready;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.disp_out  = rd_q;
  assign bus.disp_err  = err_q;
  assign bus.underrun  = urun_q;

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Directed bench for tx_serializer_10b (MSB_FIRST=1, RD_INIT=0, IDLE_FILL_EN undefined).
// Back-to-back symbol table with hand-computed RD/error results, plus underrun and mid-symbol reset sequences.
module tb_tx_serializer_10b;

  logic clk = 1'b0;
  logic rst;

  tx_serializer_10b_if bus ();

  tx_serializer_10b #(
    .MSB_FIRST (1'b1),
    .RD_INIT   (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] sym;
    logic       exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] s;

    rst           = 1'b1;
    bus.sym_in    = '0;
    bus.sym_valid = 1'b0;

    // Symbol stream chained from RD- after reset; exp_rd is RD after each symbol.
    vecs[0] = '{10'b0011111010, 1'b1, 1'b0}; // 6 ones at RD-
    vecs[1] = '{10'b1111100101, 1'b1, 1'b1}; // 7 ones
    vecs[2] = '{10'b1100000101, 1'b0, 1'b0}; // 4 ones at RD+
    vecs[3] = '{10'b0111001010, 1'b0, 1'b0}; // 5 ones
    vecs[4] = '{10'b1100000101, 1'b0, 1'b1}; // 4 ones at RD-
    vecs[5] = '{10'b0011111010, 1'b1, 1'b0}; // 6 ones at RD-
    vecs[6] = '{10'b0011111010, 1'b1, 1'b1}; // 6 ones at RD+
    vecs[7] = '{10'b1111111111, 1'b1, 1'b1}; // 10 ones
    vecs[8] = '{10'b0000000000, 1'b0, 1'b1}; // 0 ones

    repeat (2) @(posedge clk);
    #1;
    chk("ready_during_rst", bus.sym_ready, 1'b0);
    chk("valid_during_rst", bus.ser_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_ser_out",   bus.ser_out,   1'b0);
    chk("rst_ser_valid", bus.ser_valid, 1'b0);
    chk("rst_disp_out",  bus.disp_out,  1'b0);
    chk("rst_disp_err",  bus.disp_err,  1'b0);
    chk("rst_underrun",  bus.underrun,  1'b0);
    chk("rst_sym_ready", bus.sym_ready, 1'b1);

    // Back-to-back stream with sym_valid held high throughout.
    bus.sym_in    = vecs[0].sym;
    bus.sym_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      for (int b = 0; b < 10; b++) begin
        step();
        s = vecs[k].sym;
        chk($sformatf("v%0d_b%0d_ser_out", k, b),   bus.ser_out,   s[9-b]);
        chk($sformatf("v%0d_b%0d_ser_valid", k, b), bus.ser_valid, 1'b1);
        chk($sformatf("v%0d_b%0d_sym_ready", k, b), bus.sym_ready, (b == 9));
        chk($sformatf("v%0d_b%0d_underrun", k, b),  bus.underrun,  1'b0);
        chk($sformatf("v%0d_b%0d_disp_out", k, b),  bus.disp_out,  vecs[k].exp_rd);
        chk($sformatf("v%0d_b%0d_disp_err", k, b),  bus.disp_err,  (b == 0) ? vecs[k].exp_err : 1'b0);
        if (b == 9) begin
          if (k < 8) bus.sym_in = vecs[k+1].sym;
          else       bus.sym_valid = 1'b0;
        end
      end
    end

    // Stream ran dry: single underrun pulse, line idles low.
    step();
    chk("ur_pulse",     bus.underrun,  1'b1);
    chk("ur_ser_valid", bus.ser_valid, 1'b0);
    chk("ur_ser_out",   bus.ser_out,   1'b0);
    chk("ur_disp_out",  bus.disp_out,  1'b0);
    chk("ur_sym_ready", bus.sym_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("idle%0d_underrun", i),  bus.underrun,  1'b0);
      chk($sformatf("idle%0d_ser_valid", i), bus.ser_valid, 1'b0);
    end

    // Reset asserted while bit 4 of K28.5 RD- is on the line.
    s             = 10'b0011111010;
    bus.sym_in    = s;
    bus.sym_valid = 1'b1;
    step();
    bus.sym_valid = 1'b0;
    chk("mid_b0", bus.ser_out, s[9]);
    repeat (4) step();
    chk("mid_b4_ser_out",   bus.ser_out,   s[5]);
    chk("mid_b4_ser_valid", bus.ser_valid, 1'b1);
    chk("mid_b4_disp_out",  bus.disp_out,  1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ser_valid", bus.ser_valid, 1'b0);
    chk("mid_rst_ser_out",   bus.ser_out,   1'b0);
    chk("mid_rst_disp_out",  bus.disp_out,  1'b0);
    chk("mid_rst_sym_ready", bus.sym_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_sym_ready", bus.sym_ready, 1'b1);

    // Next symbol after release starts from bit 0; 4 ones at RD- is illegal.
    s             = 10'b1100000101;
    bus.sym_in    = s;
    bus.sym_valid = 1'b1;
    for (int b = 0; b < 10; b++) begin
      step();
      bus.sym_valid = 1'b0;
      chk($sformatf("post_b%0d_ser_out", b),   bus.ser_out,   s[9-b]);
      chk($sformatf("post_b%0d_ser_valid", b), bus.ser_valid, 1'b1);
      chk($sformatf("post_b%0d_disp_err", b),  bus.disp_err,  (b == 0));
      chk($sformatf("post_b%0d_disp_out", b),  bus.disp_out,  1'b0);
    end
    step();
    chk("post_underrun",  bus.underrun,  1'b1);
    chk("post_ser_valid", bus.ser_valid, 1'b0);
    step();
    chk("post_underrun_clear", bus.underrun, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
